regfile_dump_reader: RTL
========================

# regfile_dump_reader

Sequential reader for the 32×32 processor register file: on a start pulse it walks a programmed register range through one register-file read port and streams each value out over a valid/ready interface, tagged with its index. It is used for debug and verification dumps of architectural state. It sits beside the datapath, with its read address muxed onto a read port, and produces a running checksum of the words it transfers.

## Interface
Parameters:
- SKIP_ZERO, default 0: when 1, register index 0 is never read or transferred.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  begin a dump; honoured only in IDLE.
- first_reg  in  5  first index to dump; sampled when start is accepted.
- last_reg  in  5  final index to dump; sampled when start is accepted.
- rd_addr  out  5  register-file read address (Read_reg-style).
- rd_data  in  32  combinational read data returned for rd_addr.
- out_valid  out  1  out_data, out_index and out_last are valid.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  32  register value.
- out_index  out  5  register index of out_data.
- out_last  out  1  marks the final word of the dump.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at the end of a dump.
- checksum  out  32  sum of all transferred words, modulo 2^32.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - start=1 latches first_reg and last_reg, clears checksum, and sets idx=first_reg.
  - The next state is READ. If SKIP_ZERO=1 and idx==0, idx first advances: to 1 if last_reg≠0, otherwise the next state is DONE.
- READ (1 cycle):
  - rd_addr=idx.
  - rd_data is captured into out_data; out_index=idx; out_last=(idx==last).
  - The next state is SEND.
- SEND:
  - out_valid=1. out_data, out_index and out_last are held stable until the handshake (out_valid & out_ready).
  - On the handshake, checksum += out_data.
  - If out_last, the next state is DONE.
  - Otherwise idx=idx+1 mod 32. If SKIP_ZERO=1 and the new idx is 0, idx advances again to 1, or the next state is DONE if last==0. The next state is READ.
- DONE (1 cycle):
  - done=1, busy=0, then the next state is IDLE.
  - checksum holds its value until the next accepted start.
- Range wrap: if first_reg > last_reg, the walk wraps 31→0 and ends at last_reg. first_reg==last_reg dumps exactly one word.
- start is ignored in READ, SEND and DONE.
- Data reflects register contents at the READ cycle. A register-file write during the dump is visible only for indices read after it.
- The reader never drives a write port.

## Timing
- Reset values: state=IDLE, rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, checksum=0.
- Reset during any state aborts the dump with no done pulse and no further out_valid.
- Latency:
  - start at cycle T puts READ at T+1, with the first out_valid at T+2.
  - With out_ready held at 1, each word takes 2 cycles.
  - An N-word dump gives done at T+2N+1.
- rd_addr is driven only in READ and holds its last value otherwise.
- Backpressure: out_ready low holds SEND indefinitely. out_valid never drops without a handshake, except on reset.
- out_ready is ignored when out_valid=0.
- checksum updates the cycle after each handshake and is final when done is high.

## Test plan
- Full dump: regfile x[i]=i*0x11, first=0, last=31, SKIP_ZERO=0, out_ready=1.
  - Expect 32 words with index 0..31 and data i*0x11.
  - Expect out_last only on index 31.
  - Expect done at T+65 and checksum=0x0000_20F0.
- Wrap range: first=30, last=1.
  - Expect indices 30,31,0,1 in order, out_last on 1, and done after 4 handshakes.
- SKIP_ZERO=1:
  - first=0, last=2 gives words 1,2 only.
  - first=0, last=0 gives no out_valid and done at T+1.
- Backpressure: hold out_ready=0 for 5 cycles during SEND of index 4.
  - out_valid, out_data and out_index stay stable; no advance and no checksum change.
  - Release gives exactly one transfer.
- Start while busy: pulse start with different first_reg mid-dump.
  - The pulse is ignored; the original range completes unchanged.
- Reset mid-dump: assert reset during SEND of the third word.
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - A new start then dumps from its own first_reg.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Walks a programmed register range through one register-file read port and
// streams each value out over valid/ready, tagged with its index, while summing a checksum.
module regfile_dump_reader #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  first_reg,
    input  logic [4:0]  last_reg,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [4:0]  idx_reg, idx_next;
    logic [4:0]  end_idx_reg, end_idx_next;
    logic [4:0]  rd_addr_reg, rd_addr_next;
    logic [31:0] data_reg, data_next;
    logic [4:0]  index_reg, index_next;
    logic        last_flag_reg, last_flag_next;
    logic [31:0] checksum_reg, checksum_next;
    logic [4:0]  idx_inc;

    assign idx_inc = idx_reg + 5'd1;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        end_idx_next   = end_idx_reg;
        rd_addr_next   = rd_addr_reg;
        data_next      = data_reg;
        index_next     = index_reg;
        last_flag_next = last_flag_reg;
        checksum_next  = checksum_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    end_idx_next  = last_reg;
                    checksum_next = 32'd0;
                    idx_next      = first_reg;
                    state_next    = ST_READ;
                    // Index 0 is skipped up front; a range ending at 0 is then empty.
                    if (SKIP_ZERO && first_reg == 5'd0) begin
                        if (last_reg != 5'd0) begin
                            idx_next = 5'd1;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end
                end
            end
            ST_READ: begin
                data_next      = rd_data;
                index_next     = idx_reg;
                last_flag_next = (idx_reg == end_idx_reg);
                state_next     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    checksum_next = checksum_reg + data_reg;
                    if (last_flag_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_inc;
                        state_next = ST_READ;
                        // Wrapping onto a skipped index 0 either hops to 1 or ends the walk.
                        if (SKIP_ZERO && idx_inc == 5'd0) begin
                            if (end_idx_reg == 5'd0) begin
                                state_next = ST_DONE;
                            end else begin
                                idx_next = 5'd1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Address is presented for the whole READ cycle, otherwise it holds.
        if (state_next == ST_READ) begin
            rd_addr_next = idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= 5'd0;
            end_idx_reg   <= 5'd0;
            rd_addr_reg   <= 5'd0;
            data_reg      <= 32'd0;
            index_reg     <= 5'd0;
            last_flag_reg <= 1'b0;
            checksum_reg  <= 32'd0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            end_idx_reg   <= end_idx_next;
            rd_addr_reg   <= rd_addr_next;
            data_reg      <= data_next;
            index_reg     <= index_next;
            last_flag_reg <= last_flag_next;
            checksum_reg  <= checksum_next;
        end
    end

    assign rd_addr   = rd_addr_reg;
    assign out_valid = (state_reg == ST_SEND);
    assign out_data  = data_reg;
    assign out_index = index_reg;
    assign out_last  = last_flag_reg;
    assign busy      = (state_reg == ST_READ) || (state_reg == ST_SEND);
    assign done      = (state_reg == ST_DONE);
    assign checksum  = checksum_reg;

endmodule
